// File: rtl/intersection_scheduler_if.sv
// Sensor/button inputs and light-driver outputs of the intersection scheduler.
//   car_present, ped_req, preempt : raw asynchronous levels into the scheduler
//   light_wash, light_pros        : light heads, bit0 red, bit1 yellow, bit2 green
//   walk                          : walk indication
//   ped_ack                       : one-cycle pulse when a new walk request is latched
//   phase                         : current state code
// master drives the inputs (sensor side); slave is the scheduler.
interface intersection_scheduler_if;
  logic       car_present;
  logic       ped_req;
  logic       preempt;
  logic [2:0] light_wash;
  logic [2:0] light_pros;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output car_present, ped_req, preempt,
    input  light_wash, light_pros, walk, ped_ack, phase
  );

  modport slave (
    input  car_present, ped_req, preempt,
    output light_wash, light_pros, walk, ped_ack, phase
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Prospect/Washington intersection timing and arbitration controller.
// A free-running prescaler makes a tick every TICK_DIV cycles; a Moore FSM sequences
// both heads through green, yellow and all-red, arbitrates the cross phase between
// Prospect cars and pedestrians (alternating on ties), and honours an emergency preempt
// that returns right-of-way to Washington.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : slave side of intersection_scheduler_if (raw inputs in, lights/walk/ack/phase out)
module intersection_scheduler #(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned MAX_GREEN   = 10,
  parameter int unsigned YLW_TIME    = 2,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned WALK_TIME   = 6
) (
  input logic                     clk,
  input logic                     rst,
  intersection_scheduler_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);
  localparam logic [7:0]      MinLast  = 8'(MIN_GREEN - 1);
  localparam logic [7:0]      MaxLast  = 8'(MAX_GREEN - 1);
  localparam logic [7:0]      YlwLast  = 8'(YLW_TIME - 1);
  localparam logic [7:0]      ArLast   = 8'(ALLRED_TIME - 1);
  localparam logic [7:0]      WalkLast = 8'(WALK_TIME - 1);

  typedef enum logic [2:0] {
    StWGrn   = 3'd0,
    StWYlw   = 3'd1,
    StArSide = 3'd2,
    StPGrn   = 3'd3,
    StPYlw   = 3'd4,
    StArMain = 3'd5,
    StWalk   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] presc_q, presc_d;
  logic [7:0]      timer_q, timer_d;
  // Two-flop synchronizers; bit 1 is the value safe to use.
  logic [1:0]      car_sync_q, ped_sync_q, pre_sync_q;
  logic            car_req_q, car_req_d;
  logic            ped_pend_q, ped_pend_d;
  logic            last_grant_q, last_grant_d;  // 0 = car, 1 = ped
  logic            ped_ack_q;

  logic tick, car_sync, ped_sync, pre_sync;
  logic enter_pgrn, enter_walk;

  assign tick     = (presc_q == TickLast);
  assign car_sync = car_sync_q[1];
  assign ped_sync = ped_sync_q[1];
  assign pre_sync = pre_sync_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWGrn: begin
        if (tick && timer_q >= MinLast && !pre_sync && (car_req_q || ped_pend_q)) begin
          state_d = StWYlw;
        end
      end
      StWYlw: begin
        if (tick && timer_q == YlwLast) state_d = StArSide;
      end
      StArSide: begin
        if (tick && timer_q == ArLast) begin
          if (pre_sync)                     state_d = StWGrn;
          // On a tie, grant whichever side was not served last.
          else if (car_req_q && ped_pend_q) state_d = last_grant_q ? StPGrn : StWalk;
          else if (car_req_q)               state_d = StPGrn;
          else if (ped_pend_q)              state_d = StWalk;
          else                              state_d = StWGrn;
        end
      end
      StPGrn: begin
        // Preempt ends the Prospect green without waiting for a tick.
        if (pre_sync ||
            (tick && ((timer_q >= MinLast && !car_sync) || timer_q == MaxLast))) begin
          state_d = StPYlw;
        end
      end
      StPYlw: begin
        if (tick && timer_q == YlwLast) state_d = StArMain;
      end
      StWalk: begin
        if (pre_sync || (tick && timer_q == WalkLast)) state_d = StArMain;
      end
      StArMain: begin
        if (tick && timer_q == ArLast) state_d = StWGrn;
      end
      default: state_d = StWGrn;
    endcase
  end

  assign enter_pgrn = (state_d == StPGrn) && (state_q != StPGrn);
  assign enter_walk = (state_d == StWalk) && (state_q != StWalk);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;

    if (state_d != state_q)          timer_d = '0;
    else if (tick && timer_q != 8'hff) timer_d = timer_q + 8'd1;
    else                             timer_d = timer_q;

    // Clearing on grant wins over a simultaneous set.
    car_req_d  = enter_pgrn ? 1'b0 : (car_req_q | car_sync);
    ped_pend_d = enter_walk ? 1'b0 : (ped_pend_q | ped_sync);

    last_grant_d = last_grant_q;
    if (enter_pgrn) last_grant_d = 1'b0;
    if (enter_walk) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWGrn;
      presc_q      <= '0;
      timer_q      <= '0;
      car_sync_q   <= '0;
      ped_sync_q   <= '0;
      pre_sync_q   <= '0;
      car_req_q    <= 1'b0;
      ped_pend_q   <= 1'b0;
      last_grant_q <= 1'b1;
      ped_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      timer_q      <= timer_d;
      car_sync_q   <= {car_sync_q[0], bus.car_present};
      ped_sync_q   <= {ped_sync_q[0], bus.ped_req};
      pre_sync_q   <= {pre_sync_q[0], bus.preempt};
      car_req_q    <= car_req_d;
      ped_pend_q   <= ped_pend_d;
      last_grant_q <= last_grant_d;
      ped_ack_q    <= ped_pend_d & ~ped_pend_q;
    end
  end

  always_comb begin
    bus.light_wash = 3'b001;
    bus.light_pros = 3'b001;
    bus.walk       = 1'b0;
    case (state_q)
      StWGrn: bus.light_wash = 3'b100;
      StWYlw: bus.light_wash = 3'b010;
      StPGrn: bus.light_pros = 3'b100;
      StPYlw: bus.light_pros = 3'b010;
      StWalk: bus.walk       = 1'b1;
      default: ;
    endcase
  end

  assign bus.phase   = state_q;
  assign bus.ped_ack = ped_ack_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: phase-sequence vector table, hand-written corner
// sequences, and randomized inputs checked every cycle against a tick-level reference model.
module tb_intersection_scheduler;

  localparam int TickDiv  = 4;
  localparam int MinGreen = 3;
  localparam int MaxGreen = 5;
  localparam int YlwTime  = 2;
  localparam int ArTime   = 1;
  localparam int WalkTime = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  intersection_scheduler_if bus ();

  intersection_scheduler #(
    .TICK_DIV   (TickDiv),
    .MIN_GREEN  (MinGreen),
    .MAX_GREEN  (MaxGreen),
    .YLW_TIME   (YlwTime),
    .ALLRED_TIME(ArTime),
    .WALK_TIME  (WalkTime)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int acks     = 0;
  bit pulse_clr = 1'b0;

  // Reference model: phase number, ticks elapsed in phase, prescaler count, pending flags.
  int m_phase, m_ticks, m_cnt;
  bit m_car, m_ped, m_last, m_ack;
  bit cs[2], ps[2], es[2];

  function automatic int dur(input int p);
    case (p)
      1, 4:    return YlwTime;
      2, 5:    return ArTime;
      6:       return WalkTime;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] exp_wash(input int p);
    case (p)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] exp_pros(input int p);
    case (p)
      3:       return 3'b100;
      4:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit tick, car_s, ped_s, pre_s, done, new_car, new_ped;
    int nxt, elapsed;
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_cnt = 0;
      m_car = 0; m_ped = 0; m_last = 1; m_ack = 0;
      cs = '{0, 0}; ps = '{0, 0}; es = '{0, 0};
      return;
    end
    tick    = (m_cnt == TickDiv - 1);
    car_s   = cs[1];
    ped_s   = ps[1];
    pre_s   = es[1];
    elapsed = m_ticks + 1;  // ticks counted in this phase if this edge is a tick
    done    = tick && (elapsed == dur(m_phase));
    nxt     = m_phase;
    case (m_phase)
      0: if (tick && elapsed >= MinGreen && !pre_s && (m_car || m_ped)) nxt = 1;
      1: if (done) nxt = 2;
      2: if (done) begin
        if (pre_s)              nxt = 0;
        else if (m_car && m_ped) nxt = m_last ? 3 : 6;
        else if (m_car)          nxt = 3;
        else if (m_ped)          nxt = 6;
        else                     nxt = 0;
      end
      3: if (pre_s || (tick && ((elapsed >= MinGreen && !car_s) || elapsed == MaxGreen))) nxt = 4;
      4: if (done) nxt = 5;
      5: if (done) nxt = 0;
      6: if (pre_s || done) nxt = 5;
      default: nxt = 0;
    endcase
    new_car = (nxt == 3 && m_phase != 3) ? 1'b0 : (m_car | car_s);
    new_ped = (nxt == 6 && m_phase != 6) ? 1'b0 : (m_ped | ped_s);
    m_ack   = !m_ped && new_ped;
    if (nxt == 3 && m_phase != 3) m_last = 0;
    if (nxt == 6 && m_phase != 6) m_last = 1;
    if (nxt != m_phase) m_ticks = 0;
    else if (tick && m_ticks < 255) m_ticks++;
    m_phase = nxt;
    m_car   = new_car;
    m_ped   = new_ped;
    m_cnt   = tick ? 0 : m_cnt + 1;
    cs[1] = cs[0]; cs[0] = bus.car_present;
    ps[1] = ps[0]; ps[0] = bus.ped_req;
    es[1] = es[0]; es[0] = bus.preempt;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_phase", bus.phase, m_phase);
    check("model_wash", bus.light_wash, exp_wash(m_phase));
    check("model_pros", bus.light_pros, exp_pros(m_phase));
    check("model_walk", bus.walk, (m_phase == 6) ? 1 : 0);
    check("model_ack", bus.ped_ack, m_ack);
    if (bus.ped_ack) acks++;
    if (pulse_clr) begin
      bus.car_present = 1'b0;
      bus.ped_req     = 1'b0;
      bus.preempt     = 1'b0;
      pulse_clr       = 1'b0;
    end
  endtask

  task automatic do_reset();
    bus.car_present = 1'b0;
    bus.ped_req     = 1'b0;
    bus.preempt     = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_phase(input string name, input int ph, input int limit);
    int n = 0;
    while (int'(bus.phase) != ph && n < limit) begin
      step();
      n++;
    end
    check(name, bus.phase, ph);
  endtask

  typedef struct {
    bit         rst_before;
    bit         car, ped, pre, pulse;
    int         ph;
    logic [2:0] wash, pros;
    bit         walk;
    int         cycles;  // expected cycles spent in ph; 0 = not measured
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit c, input bit p, input bit e, input bit pl,
                     input int ph, input logic [2:0] w, input logic [2:0] pr, input bit wk,
                     input int cyc);
    vec_t v;
    v = '{r, c, p, e, pl, ph, w, pr, wk, cyc};
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    int n;
    if (v.rst_before) do_reset();
    bus.car_present = v.car;
    bus.ped_req     = v.ped;
    bus.preempt     = v.pre;
    pulse_clr       = v.pulse;
    wait_phase($sformatf("vec%0d_reach", i), v.ph, 200);
    check($sformatf("vec%0d_wash", i), bus.light_wash, v.wash);
    check($sformatf("vec%0d_pros", i), bus.light_pros, v.pros);
    check($sformatf("vec%0d_walk", i), bus.walk, v.walk);
    if (v.cycles != 0) begin
      n = 0;
      while (int'(bus.phase) == v.ph && n < 400) begin
        n++;
        step();
      end
      check($sformatf("vec%0d_cycles", i), n, v.cycles);
    end
  endtask

  initial begin
    int  ok;
    bus.car_present = 1'b0;
    bus.ped_req     = 1'b0;
    bus.preempt     = 1'b0;

    // Car pulse: full cycle through the Prospect phase at minimum green.
    add(0, 1, 0, 0, 1, 1, 3'b010, 3'b001, 0, 8);
    add(0, 0, 0, 0, 0, 2, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 3, 3'b001, 3'b100, 0, 12);
    add(0, 0, 0, 0, 0, 4, 3'b001, 3'b010, 0, 8);
    add(0, 0, 0, 0, 0, 5, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 0, 3'b100, 3'b001, 0, 0);
    // Car held: Prospect green runs to the cap; Washington re-requested after min green.
    add(0, 1, 0, 0, 0, 1, 3'b010, 3'b001, 0, 8);
    add(0, 1, 0, 0, 0, 2, 3'b001, 3'b001, 0, 4);
    add(0, 1, 0, 0, 0, 3, 3'b001, 3'b100, 0, 20);
    add(0, 1, 0, 0, 0, 4, 3'b001, 3'b010, 0, 8);
    add(0, 1, 0, 0, 0, 5, 3'b001, 3'b001, 0, 4);
    add(0, 1, 0, 0, 0, 0, 3'b100, 3'b001, 0, 12);
    add(0, 0, 0, 0, 0, 1, 3'b010, 3'b001, 0, 8);
    add(0, 0, 0, 0, 0, 2, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 3, 3'b001, 3'b100, 0, 12);
    add(0, 0, 0, 0, 0, 4, 3'b001, 3'b010, 0, 8);
    add(0, 0, 0, 0, 0, 5, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 0, 3'b100, 3'b001, 0, 0);
    // Car and ped together after reset: car first, then walk; re-press while pending.
    add(1, 1, 1, 0, 1, 1, 3'b010, 3'b001, 0, 8);
    add(0, 0, 0, 0, 0, 2, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 3, 3'b001, 3'b100, 0, 12);
    add(0, 0, 1, 0, 1, 4, 3'b001, 3'b010, 0, 8);
    add(0, 0, 0, 0, 0, 5, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 0, 3'b100, 3'b001, 0, 12);
    add(0, 0, 0, 0, 0, 1, 3'b010, 3'b001, 0, 8);
    add(0, 0, 0, 0, 0, 2, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 6, 3'b001, 3'b001, 1, 8);
    add(0, 0, 0, 0, 0, 5, 3'b001, 3'b001, 0, 4);
    add(0, 0, 0, 0, 0, 0, 3'b100, 3'b001, 0, 0);

    // Reset and idle.
    do_reset();
    check("rst_phase", bus.phase, 0);
    check("rst_wash", bus.light_wash, 3'b100);
    check("rst_pros", bus.light_pros, 3'b001);
    check("rst_walk", bus.walk, 0);
    acks = 0;
    ok = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.phase != 3'd0 || bus.light_wash != 3'b100 || bus.walk) ok = 0;
    end
    check("idle_hold", ok, 1);
    check("idle_acks", acks, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 18) acks = 0;
      apply_vec(i, vecs[i]);
      if (i == 28) check("tie_acks", acks, 1);
    end

    // Preempt during Prospect green: exit on the 3rd edge, then held preempt blocks cars.
    do_reset();
    bus.car_present = 1'b1;
    wait_phase("pre_reach_pgrn", 3, 200);
    for (int i = 0; i < 4; i++) step();
    bus.preempt = 1'b1;
    step();
    step();
    check("pre_edge2", bus.phase, 3);
    step();
    check("pre_edge3", bus.phase, 4);
    wait_phase("pre_armain", 5, 20);
    wait_phase("pre_wgrn", 0, 20);
    ok = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.phase != 3'd0) ok = 0;
    end
    check("pre_hold_wgrn", ok, 1);
    bus.preempt     = 1'b0;
    bus.car_present = 1'b0;

    // Reset mid-walk discards a pending car request.
    do_reset();
    bus.ped_req = 1'b1;
    pulse_clr   = 1'b1;
    wait_phase("rw_reach_walk", 6, 200);
    bus.car_present = 1'b1;
    pulse_clr       = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rw_walk_on", bus.walk, 1);
    rst = 1'b1;
    step();
    check("rw_phase", bus.phase, 0);
    check("rw_walk_off", bus.walk, 0);
    rst = 1'b0;
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.phase != 3'd0) ok = 0;
    end
    check("rw_pending_cleared", ok, 1);

    // Randomized levels with occasional resets, checked against the model each cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.car_present = ~bus.car_present;
      if ($urandom_range(0, 19) == 0) bus.ped_req = ~bus.ped_req;
      if ($urandom_range(0, 59) == 0) bus.preempt = ~bus.preempt;
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Timing and arbitration controller for the Prospect/Washington intersection. Free-running prescaler generates a one-second tick; a Moore state machine sequences both light heads through green, yellow and all-red clearance phases. It arbitrates the shared cross phase between Prospect car requests and pedestrian walk requests and honours an emergency preempt that returns right-of-way to Washington. Sits between raw sensor and button inputs and the light drivers.

## Interface
- TICK_DIV, 25000000, clk cycles per tick (≥2)
- MIN_GREEN, 5, minimum green per phase, ticks (1..255, ≤MAX_GREEN)
- MAX_GREEN, 10, Prospect green extension cap, ticks (1..255)
- YLW_TIME, 2, yellow duration, ticks (1..255)
- ALLRED_TIME, 1, all-red clearance, ticks (1..255)
- WALK_TIME, 6, walk duration, ticks (1..255)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- car_present  in  1  Prospect car sensor, asynchronous level
- ped_req  in  1  walk button, asynchronous level
- preempt  in  1  emergency preempt for Washington, asynchronous level
- light_wash  out  3  Washington head, bit0 red, bit1 yellow, bit2 green
- light_pros  out  3  Prospect head, same encoding
- walk  out  1  walk indication
- ped_ack  out  1  one-cycle pulse when a new walk request is latched
- phase  out  3  current state code

## Operation
- car_present, ped_req, preempt each pass a 2-flop synchronizer (reset 0) before use.
- States/codes: W_GRN 0, W_YLW 1, AR_SIDE 2, P_GRN 3, P_YLW 4, AR_MAIN 5, WALK 6. Codes 7 and unused: recover to W_GRN next cycle.
- Lights (decoded from state): W_GRN wash 100/pros 001; W_YLW 010/001; P_GRN 001/100; P_YLW 001/010; AR_SIDE, AR_MAIN, WALK 001/001. walk=1 only in WALK.
- car_req: set on any cycle car_sync=1; cleared on the edge entering P_GRN (clear wins).
- ped_pend: set on any cycle ped_sync=1; cleared on the edge entering WALK (clear wins). ped_ack pulses the cycle after ped_pend goes 0→1.
- last_grant: 0=car, 1=ped; updated on entering P_GRN/WALK; reset value 1 (car wins first tie).
- W_GRN: exit to W_YLW on tick when timer ≥ MIN_GREEN-1, preempt_sync=0, and (car_req or ped_pend). Otherwise holds indefinitely.
- W_YLW: YLW_TIME ticks → AR_SIDE.
- AR_SIDE: ALLRED_TIME ticks, then: preempt_sync → W_GRN; car_req and ped_pend → grant opposite of last_grant; only one pending → it (car → P_GRN, ped → WALK); neither → W_GRN.
- P_GRN: → P_YLW on tick when (timer ≥ MIN_GREEN-1 and car_sync=0) or timer = MAX_GREEN-1; immediately (next edge, no tick needed) when preempt_sync=1.
- P_YLW: YLW_TIME ticks → AR_MAIN (not shortened by preempt).
- WALK: WALK_TIME ticks → AR_MAIN; preempt_sync=1 → AR_MAIN next edge.
- AR_MAIN: ALLRED_TIME ticks → W_GRN.

## Timing
- Prescaler: 0..TICK_DIV-1, free-running, never reset by state change; tick=1 for the single cycle count = TICK_DIV-1.
- Phase timer: 8-bit, zeroed on every state-entry edge, +1 per tick, saturates at 255.
- "N ticks" exit: transition on the edge where tick=1 and timer = N-1; state occupies N tick boundaries after entry (first interval partial).
- Input-to-state latency: 2 cycles synchronizer; car_req/ped_pend set on 3rd edge; preempt exit from P_GRN/WALK on 3rd edge after preempt rises.
- Reset (edge with rst=1): state W_GRN, prescaler 0, timer 0, car_req 0, ped_pend 0, last_grant 1, synchronizers 0, ped_ack 0; outputs thereafter wash 100, pros 001, walk 0, phase 0. rst mid-phase aborts immediately, pending requests discarded.
- Outputs are pure state decode; no glitch-free guarantee beyond registered state.

## Test plan
Use TICK_DIV=4, MIN_GREEN=3, MAX_GREEN=5, YLW_TIME=2, ALLRED_TIME=1, WALK_TIME=2.
- Reset, no inputs for 200 cycles -> phase 0, wash 100, pros 001, walk 0, ped_ack never asserts.
- car_present pulsed 1 cycle at t=20 -> W_YLW (wash 010) at first tick with timer ≥2, AR_SIDE 001/001, P_GRN pros 100 exactly 3 ticks, P_YLW 2 ticks, AR_MAIN 1 tick, back to phase 0.
- car_present held high -> P_GRN lasts exactly 5 ticks (MAX_GREEN) then P_YLW; W_GRN re-requested after min green.
- car_present and ped_req asserted same cycle -> car served first, then WALK (walk=1, both 001, 2 ticks); ped_ack one pulse per rising press, none on re-press while pending.
- preempt raised mid-P_GRN -> P_YLW on 3rd edge, AR_MAIN, W_GRN; held preempt keeps phase 0 despite car_req=1.
- rst asserted mid-WALK -> next edge phase 0, walk 0, pending requests cleared.
